// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer: store packets, bus commands, buffer entries, drain states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package store_write_buffer_pkg;

   localparam int NUM_SQ_DCACHE = 2;
   localparam int WB_LEN        = 4;
   localparam int NUM_FU_LOAD   = 2;
   localparam int WB_IDX_W      = $clog2(WB_LEN);

   typedef logic [31:0]         ADDR;
   typedef logic [WB_IDX_W-1:0] WB_IDX;
   typedef logic [WB_IDX_W:0]   WB_CNT;

   typedef enum logic [1:0] {
      BYTE = 2'h0,
      HALF = 2'h1,
      WORD = 2'h2
   } MEM_SIZE;

   typedef struct packed {
      logic    is_unsigned;
      MEM_SIZE size;
   } MEM_FUNC;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef struct packed {
      logic        valid;
      ADDR         addr;
      MEM_FUNC     sign_size;
      logic [31:0] data;
   } SQ_DCACHE_PACKET;

   typedef struct packed {
      logic        valid;
      ADDR         block_addr;
      logic [63:0] data;
      logic [7:0]  mask;
   } WB_ENTRY;

   typedef enum logic [1:0] {
      WB_IDLE      = 2'h0,
      WB_LOAD_REQ  = 2'h1,
      WB_LOAD_WAIT = 2'h2,
      WB_STORE_REQ = 2'h3
   } WB_STATE;

   // 8-byte block address of any byte address.
   function automatic ADDR block_of(input ADDR a);
      return a & ~ADDR'(7);
   endfunction

   // Bytes of upd selected by mask replace the corresponding bytes of base.
   function automatic logic [63:0] merge_bytes(input logic [63:0] base,
                                               input logic [63:0] upd,
                                               input logic [7:0]  mask);
      logic [63:0] res;
      res = base;
      for (int b = 0; b < 8; b++) begin
         if (mask[b]) res[b*8 +: 8] = upd[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/store_write_buffer_byte_merge.sv
// Places one store's data into its byte lanes of a 64-bit block and builds the byte mask.
// Latency: combinational.
// Backpressure: none.
module wb_byte_merge
   import store_write_buffer_pkg::*;
(
   input  logic [2:0]  addr,
   input  MEM_SIZE     size,
   input  logic [31:0] data,
   output logic [63:0] lane_data,
   output logic [7:0]  lane_mask
);

   logic [31:0] sized_data;
   logic [7:0]  sized_mask;

   // Trim data to the access size so bytes above it never reach the block.
   always_comb begin
      sized_data = '0;
      sized_mask = '0;
      case (size)
         BYTE: begin sized_data = {24'h0, data[7:0]};  sized_mask = 8'h01; end
         HALF: begin sized_data = {16'h0, data[15:0]}; sized_mask = 8'h03; end
         WORD: begin sized_data = data;                sized_mask = 8'h0F; end
         default: begin sized_data = '0;               sized_mask = 8'h00; end
      endcase
   end

   assign lane_data = {32'h0, sized_data} << {addr, 3'b000};
   assign lane_mask = sized_mask << addr;

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: accepts committed stores into 8-byte entries, drains oldest-first to memory (RMW for partial blocks).
// Latency: accept is same-cycle; entry written next edge; drain FSM leaves IDLE one cycle after allocation at earliest.
// Backpressure: dcache_accept drops (prefix only) when entries run out; a freed entry gives credit one cycle later. Build macro STORE_WB_MERGE_EN enables store merging.
module store_write_buffer
   import store_write_buffer_pkg::*;
(
   input  logic                                clock,
   input  logic                                reset,
   input  SQ_DCACHE_PACKET [NUM_SQ_DCACHE-1:0] sq_dcache_packet,
   output logic [NUM_SQ_DCACHE-1:0]            dcache_accept,
   output BUS_COMMAND                          proc2mem_command,
   output ADDR                                 proc2mem_addr,
   output logic [63:0]                         proc2mem_data,
   input  logic [3:0]                          mem2proc_transaction_tag,
   input  logic [3:0]                          mem2proc_data_tag,
   input  logic [63:0]                         mem2proc_data,
   input  ADDR [NUM_FU_LOAD-1:0]               lq_addr,
   output logic [NUM_FU_LOAD-1:0]              lq_stall,
   output logic                                wb_empty
);

`ifdef STORE_WB_MERGE_EN
   localparam bit MERGE_EN = 1'b1;
`else
   localparam bit MERGE_EN = 1'b0;
`endif

   localparam WB_CNT WB_FULL = WB_CNT'(WB_LEN);

   WB_ENTRY    wb     [WB_LEN];
   WB_ENTRY    wb_nxt [WB_LEN];
   WB_IDX      head;
   WB_IDX      tail;
   WB_CNT      count;
   WB_STATE    state;
   BUS_COMMAND cmd_q;
   logic [3:0] saved_tag;

   logic [NUM_SQ_DCACHE-1:0][63:0] lane_data;
   logic [NUM_SQ_DCACHE-1:0][7:0]  lane_mask;
   logic [NUM_SQ_DCACHE-1:0]       slot_alloc;
   logic [NUM_SQ_DCACHE-1:0]       slot_merge;
   WB_IDX [NUM_SQ_DCACHE-1:0]      slot_idx;
   WB_CNT                          alloc_cnt;

   WB_CNT run_cnt;
   WB_IDX next_idx;
   WB_IDX y_idx;
   logic  y_vld;
   ADDR   y_addr;
   ADDR   slot_blk;
   logic  prev_acc;

   logic fill_now;
   logic free_now;
   logic unused_sign_bits;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SQ_DCACHE; gi++) begin : g_lane
         wb_byte_merge u_merge (
            .addr      (sq_dcache_packet[gi].addr[2:0]),
            .size      (sq_dcache_packet[gi].sign_size.size),
            .data      (sq_dcache_packet[gi].data),
            .lane_data (lane_data[gi]),
            .lane_mask (lane_mask[gi])
         );
      end
   endgenerate

   // Signedness only matters on the load side; fold it away here.
   always_comb begin
      unused_sign_bits = 1'b0;
      for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
         unused_sign_bits = unused_sign_bits ^ sq_dcache_packet[i].sign_size.is_unsigned;
      end
   end

   // Walk slots oldest-first: each accepted slot either merges into the youngest non-head entry or takes the next free entry.
   always_comb begin
      dcache_accept = '0;
      slot_alloc    = '0;
      slot_merge    = '0;
      slot_idx      = '0;
      alloc_cnt     = '0;
      run_cnt       = count;
      next_idx      = tail;
      y_idx         = tail - WB_IDX'(1);
      y_vld         = MERGE_EN && (count >= WB_CNT'(2));
      y_addr        = wb[y_idx].block_addr;
      prev_acc      = !reset;
      slot_blk      = '0;
      for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
         slot_blk    = block_of(sq_dcache_packet[i].addr);
         slot_idx[i] = next_idx;
         if (prev_acc && sq_dcache_packet[i].valid) begin
            if (y_vld && (y_addr == slot_blk)) begin
               slot_merge[i]    = 1'b1;
               slot_idx[i]      = y_idx;
               dcache_accept[i] = 1'b1;
            end else if (run_cnt < WB_FULL) begin
               slot_alloc[i]    = 1'b1;
               dcache_accept[i] = 1'b1;
               // A fresh entry is mergeable only if it did not land on the head.
               y_vld            = MERGE_EN && (run_cnt != '0);
               y_idx            = next_idx;
               y_addr           = slot_blk;
               run_cnt          = run_cnt + WB_CNT'(1);
               next_idx         = next_idx + WB_IDX'(1);
               alloc_cnt        = alloc_cnt + WB_CNT'(1);
            end
         end
         prev_acc = dcache_accept[i];
      end
   end

   // Loads stall on any buffered block or any block being accepted this cycle.
   always_comb begin
      lq_stall = '0;
      for (int j = 0; j < NUM_FU_LOAD; j++) begin
         if (!reset) begin
            for (int k = 0; k < WB_LEN; k++) begin
               if (wb[k].valid && (wb[k].block_addr == block_of(lq_addr[j]))) lq_stall[j] = 1'b1;
            end
            for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
               if (dcache_accept[i] && (block_of(sq_dcache_packet[i].addr) == block_of(lq_addr[j])))
                  lq_stall[j] = 1'b1;
            end
         end
      end
   end

   assign fill_now = (state == WB_LOAD_WAIT) && (saved_tag != 4'h0) && (mem2proc_data_tag == saved_tag);
   assign free_now = (state == WB_STORE_REQ) && (mem2proc_transaction_tag != 4'h0);

   // Next entry contents: head fill/free first, then slot writes in age order so later slots win on overlap.
   always_comb begin
      wb_nxt = wb;
      if (fill_now) begin
         wb_nxt[head].data = merge_bytes(mem2proc_data, wb[head].data, wb[head].mask);
         wb_nxt[head].mask = 8'hFF;
      end
      if (free_now) begin
         wb_nxt[head] = '0;
      end
      for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
         if (slot_alloc[i]) begin
            wb_nxt[slot_idx[i]].valid      = 1'b1;
            wb_nxt[slot_idx[i]].block_addr = block_of(sq_dcache_packet[i].addr);
            wb_nxt[slot_idx[i]].data       = lane_data[i];
            wb_nxt[slot_idx[i]].mask       = lane_mask[i];
         end else if (slot_merge[i]) begin
            wb_nxt[slot_idx[i]].data = merge_bytes(wb_nxt[slot_idx[i]].data, lane_data[i], lane_mask[i]);
            wb_nxt[slot_idx[i]].mask = wb_nxt[slot_idx[i]].mask | lane_mask[i];
         end
      end
   end

   // Entry storage and ring pointers; allocation and free may happen on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < WB_LEN; k++) wb[k] <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         wb    <= wb_nxt;
         head  <= head + WB_IDX'(free_now);
         tail  <= tail + WB_IDX'(alloc_cnt);
         count <= count + alloc_cnt - WB_CNT'(free_now);
      end
   end

   // Drain FSM on the head entry with a registered bus command.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= WB_IDLE;
         cmd_q     <= BUS_NONE;
         saved_tag <= 4'h0;
      end else begin
         case (state)
            WB_IDLE: begin
               if (wb[head].valid) begin
                  if (wb[head].mask == 8'hFF) begin
                     state <= WB_STORE_REQ;
                     cmd_q <= BUS_STORE;
                  end else begin
                     state <= WB_LOAD_REQ;
                     cmd_q <= BUS_LOAD;
                  end
               end
            end
            WB_LOAD_REQ: begin
               if (mem2proc_transaction_tag != 4'h0) begin
                  saved_tag <= mem2proc_transaction_tag;
                  state     <= WB_LOAD_WAIT;
                  cmd_q     <= BUS_NONE;
               end
            end
            WB_LOAD_WAIT: begin
               if (fill_now) begin
                  state <= WB_STORE_REQ;
                  cmd_q <= BUS_STORE;
               end
            end
            WB_STORE_REQ: begin
               if (free_now) begin
                  state     <= WB_IDLE;
                  cmd_q     <= BUS_NONE;
                  saved_tag <= 4'h0;
               end
            end
            default: begin
               state <= WB_IDLE;
               cmd_q <= BUS_NONE;
            end
         endcase
      end
   end

   assign proc2mem_command = cmd_q;
   assign proc2mem_addr    = (cmd_q == BUS_NONE)  ? '0 : wb[head].block_addr;
   assign proc2mem_data    = (cmd_q == BUS_STORE) ? wb[head].data : '0;
   assign wb_empty         = (count == '0);

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: accept rules, RMW drain, full buffer, merging, reset mid-drain.
// Latency: n/a.
// Backpressure: n/a.
module tb_store_write_buffer;
   import store_write_buffer_pkg::*;

`ifdef STORE_WB_MERGE_EN
   localparam int          EXP_LOADS_200  = 0;
   localparam int          EXP_STORES_200 = 1;
   localparam logic [63:0] EXP_LAST_200   = 64'h44332211_DDCCBBAA;
`else
   localparam int          EXP_LOADS_200  = 3;
   localparam int          EXP_STORES_200 = 3;
   localparam logic [63:0] EXP_LAST_200   = 64'h44332211_00000000;
`endif

   logic                                clock;
   logic                                reset;
   SQ_DCACHE_PACKET [NUM_SQ_DCACHE-1:0] sq_pkt;
   logic [NUM_SQ_DCACHE-1:0]            accept;
   BUS_COMMAND                          cmd;
   ADDR                                 maddr;
   logic [63:0]                         mdata;
   logic [3:0]                          txn_tag;
   logic [3:0]                          data_tag;
   logic [63:0]                         mem_data;
   ADDR [NUM_FU_LOAD-1:0]               lq_addr;
   logic [NUM_FU_LOAD-1:0]              lq_stall;
   logic                                wb_empty;

   int checks;
   int errors;

   store_write_buffer dut (
      .clock                    (clock),
      .reset                    (reset),
      .sq_dcache_packet         (sq_pkt),
      .dcache_accept            (accept),
      .proc2mem_command         (cmd),
      .proc2mem_addr            (maddr),
      .proc2mem_data            (mdata),
      .mem2proc_transaction_tag (txn_tag),
      .mem2proc_data_tag        (data_tag),
      .mem2proc_data            (mem_data),
      .lq_addr                  (lq_addr),
      .lq_stall                 (lq_stall),
      .wb_empty                 (wb_empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic SQ_DCACHE_PACKET pkt(input logic v, input ADDR a, input MEM_SIZE s, input logic [31:0] d);
      SQ_DCACHE_PACKET p;
      p                = '0;
      p.valid          = v;
      p.addr           = a;
      p.sign_size.size = s;
      p.data           = d;
      return p;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; sq_pkt = '0; txn_tag = '0; data_tag = '0; mem_data = '0;
      lq_addr[0] = 32'h100; lq_addr[1] = 32'h200;
      tick(); tick();
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL reset_cmd: got %0d want %0d", cmd, BUS_NONE); end
      checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", wb_empty); end
      sq_pkt[0] = pkt(1'b1, 32'h100, WORD, 32'h1); #1;
      checks++; if (accept !== 2'b00) begin errors++; $display("FAIL reset_accept: got %b want 00", accept); end
      checks++; if (lq_stall !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b want 00", lq_stall); end
      sq_pkt = '0; reset = 1'b0;
      tick();
   endtask

   task automatic test_prefix();
      sq_pkt[0] = pkt(1'b0, 32'h400, WORD, 32'h0);
      sq_pkt[1] = pkt(1'b1, 32'h400, WORD, 32'hCAFE);
      lq_addr[0] = 32'h400; #1;
      checks++; if (accept !== 2'b00) begin errors++; $display("FAIL prefix_accept: got %b want 00", accept); end
      checks++; if (lq_stall[0] !== 1'b0) begin errors++; $display("FAIL prefix_stall: got %b want 0", lq_stall[0]); end
      tick(); sq_pkt = '0;
      checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL prefix_empty: got %b want 1", wb_empty); end
   endtask

   task automatic test_word_rmw();
      sq_pkt[0] = pkt(1'b1, 32'h100, WORD, 32'hDEADBEEF);
      lq_addr[0] = 32'h104; lq_addr[1] = 32'h108; #1;
      checks++; if (accept !== 2'b01) begin errors++; $display("FAIL rmw_accept: got %b want 01", accept); end
      checks++; if (lq_stall !== 2'b01) begin errors++; $display("FAIL rmw_stall_accepting: got %b want 01", lq_stall); end
      tick(); sq_pkt = '0;
      checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL rmw_not_empty: got %b want 0", wb_empty); end
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL rmw_idle_cmd: got %0d want %0d", cmd, BUS_NONE); end
      tick();
      for (int c = 0; c < 3; c++) begin
         checks++; if (cmd !== BUS_LOAD) begin errors++; $display("FAIL rmw_load_cmd[%0d]: got %0d want %0d", c, cmd, BUS_LOAD); end
         checks++; if (maddr !== 32'h100) begin errors++; $display("FAIL rmw_load_addr[%0d]: got %h want 00000100", c, maddr); end
         tick();
      end
      checks++; if (cmd !== BUS_LOAD) begin errors++; $display("FAIL rmw_load_held: got %0d want %0d", cmd, BUS_LOAD); end
      checks++; if (lq_stall !== 2'b01) begin errors++; $display("FAIL rmw_stall_buffered: got %b want 01", lq_stall); end
      txn_tag = 4'd3; tick(); txn_tag = 4'd0;
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL rmw_wait_cmd: got %0d want %0d", cmd, BUS_NONE); end
      data_tag = 4'd5; mem_data = 64'hFFFF_FFFF_FFFF_FFFF; tick();
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL rmw_wrong_tag: got %0d want %0d", cmd, BUS_NONE); end
      data_tag = 4'd3; mem_data = 64'h55667788_11223344; tick(); data_tag = 4'd0;
      checks++; if (cmd !== BUS_STORE) begin errors++; $display("FAIL rmw_store_cmd: got %0d want %0d", cmd, BUS_STORE); end
      checks++; if (maddr !== 32'h100) begin errors++; $display("FAIL rmw_store_addr: got %h want 00000100", maddr); end
      checks++; if (mdata !== 64'h55667788_DEADBEEF) begin errors++; $display("FAIL rmw_store_data: got %h want 55667788deadbeef", mdata); end
      txn_tag = 4'd4; tick(); txn_tag = 4'd0;
      checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL rmw_drained: got %b want 1", wb_empty); end
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL rmw_done_cmd: got %0d want %0d", cmd, BUS_NONE); end
   endtask

   task automatic test_full();
      ADDR exp_st [4];
      ADDR stores [$];
      exp_st = '{32'h308, 32'h310, 32'h318, 32'h320};
      sq_pkt[0] = pkt(1'b1, 32'h300, WORD, 32'h30);
      sq_pkt[1] = pkt(1'b1, 32'h308, WORD, 32'h31); #1;
      checks++; if (accept !== 2'b11) begin errors++; $display("FAIL full_accept_a: got %b want 11", accept); end
      tick();
      sq_pkt[0] = pkt(1'b1, 32'h310, WORD, 32'h32);
      sq_pkt[1] = pkt(1'b1, 32'h318, WORD, 32'h33); #1;
      checks++; if (accept !== 2'b11) begin errors++; $display("FAIL full_accept_b: got %b want 11", accept); end
      tick();
      sq_pkt[0] = pkt(1'b1, 32'h320, WORD, 32'h34);
      sq_pkt[1] = pkt(1'b1, 32'h328, WORD, 32'h35); #1;
      checks++; if (accept !== 2'b00) begin errors++; $display("FAIL full_accept_full: got %b want 00", accept); end
      txn_tag = 4'd1; tick(); txn_tag = 4'd0; data_tag = 4'd1; #1;
      checks++; if (accept !== 2'b00) begin errors++; $display("FAIL full_accept_wait: got %b want 00", accept); end
      tick(); data_tag = 4'd0; txn_tag = 4'd2; #1;
      checks++; if (maddr !== 32'h300) begin errors++; $display("FAIL full_head_store_addr: got %h want 00000300", maddr); end
      checks++; if (accept !== 2'b00) begin errors++; $display("FAIL full_free_no_credit: got %b want 00", accept); end
      tick(); txn_tag = 4'd0; #1;
      checks++; if (accept !== 2'b01) begin errors++; $display("FAIL full_one_credit: got %b want 01", accept); end
      tick(); sq_pkt = '0;
      txn_tag = 4'd1; data_tag = 4'd1;
      for (int c = 0; c < 40; c++) begin
         if (cmd == BUS_STORE) stores.push_back(maddr);
         tick();
      end
      txn_tag = 4'd0; data_tag = 4'd0;
      checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", wb_empty); end
      checks++; if (stores.size() != 4) begin errors++; $display("FAIL full_store_count: got %0d want 4", stores.size()); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= stores.size() || stores[k] !== exp_st[k]) begin
            errors++; $display("FAIL full_store_order[%0d]: got %h want %h", k, (k < stores.size()) ? stores[k] : 32'h0, exp_st[k]);
         end
      end
   endtask

   task automatic test_merge_fill();
      int          loads;
      int          stores;
      logic [63:0] last;
      loads = 0; stores = 0; last = '0;
      sq_pkt[0] = pkt(1'b1, 32'h100, WORD, 32'h01020304);
      tick();
      sq_pkt[0] = pkt(1'b1, 32'h200, HALF, 32'h0000BBAA);
      sq_pkt[1] = pkt(1'b1, 32'h202, HALF, 32'h0000DDCC); #1;
      checks++; if (accept !== 2'b11) begin errors++; $display("FAIL merge_accept_halves: got %b want 11", accept); end
      tick();
      sq_pkt[1] = '0;
      sq_pkt[0] = pkt(1'b1, 32'h204, WORD, 32'h44332211); #1;
      checks++; if (accept !== 2'b01) begin errors++; $display("FAIL merge_accept_word: got %b want 01", accept); end
      tick(); sq_pkt = '0;
      txn_tag = 4'd1; data_tag = 4'd1; mem_data = '0;
      for (int c = 0; c < 40; c++) begin
         if (cmd == BUS_LOAD && maddr == 32'h200) loads++;
         if (cmd == BUS_STORE && maddr == 32'h200) begin stores++; last = mdata; end
         tick();
      end
      txn_tag = 4'd0; data_tag = 4'd0;
      checks++; if (loads != EXP_LOADS_200) begin errors++; $display("FAIL merge_loads: got %0d want %0d", loads, EXP_LOADS_200); end
      checks++; if (stores != EXP_STORES_200) begin errors++; $display("FAIL merge_stores: got %0d want %0d", stores, EXP_STORES_200); end
      checks++; if (last !== EXP_LAST_200) begin errors++; $display("FAIL merge_data: got %h want %h", last, EXP_LAST_200); end
      checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL merge_drained: got %b want 1", wb_empty); end
   endtask

   task automatic test_reset_mid_drain();
      sq_pkt[0] = pkt(1'b1, 32'h500, WORD, 32'h55);
      tick(); sq_pkt = '0;
      tick();
      checks++; if (cmd !== BUS_LOAD) begin errors++; $display("FAIL rst_load_cmd: got %0d want %0d", cmd, BUS_LOAD); end
      txn_tag = 4'd7; tick(); txn_tag = 4'd0;
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL rst_wait_cmd: got %0d want %0d", cmd, BUS_NONE); end
      reset = 1'b1;
      sq_pkt[0] = pkt(1'b1, 32'h600, WORD, 32'h66);
      lq_addr[0] = 32'h500; #1;
      checks++; if (accept !== 2'b00) begin errors++; $display("FAIL rst_accept: got %b want 00", accept); end
      checks++; if (lq_stall[0] !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", lq_stall[0]); end
      tick(); reset = 1'b0; sq_pkt = '0;
      checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", wb_empty); end
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL rst_cmd: got %0d want %0d", cmd, BUS_NONE); end
      data_tag = 4'd7; mem_data = 64'hFFFF_FFFF_FFFF_FFFF; tick(); data_tag = 4'd0;
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL rst_late_data_cmd: got %0d want %0d", cmd, BUS_NONE); end
      checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL rst_late_data_empty: got %b want 1", wb_empty); end
      tick(); tick();
      checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL rst_quiet_cmd: got %0d want %0d", cmd, BUS_NONE); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_prefix();
      test_word_rmw();
      test_full();
      test_merge_fill();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
